vram_scanout: RTL

Display-side read sequencer for the dual-read-port video RAM. Owns read port 0:
- walks a frame's pixel words linearly from a programmable base address;
- absorbs the RAM's one-cycle read latency;
- buffers words in a small FIFO;
- presents a valid/ready pixel stream with end-of-line and end-of-frame markers to the DVI encoder path.

The frame is restarted by a pulse from the display timing generator.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/scanout_fifo.sv | 77 +++++++
 rtl/vram_scanout.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared video-RAM definitions: bus widths, scanout sequencer states and the
// tagged pixel word that sits in the scanout FIFO.
package vram_pkg;

    localparam int VRAM_AW = 19;
    localparam int VRAM_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic               eof;
        logic               eol;
        logic [VRAM_DW-1:0] data;
    } pix_word_t;

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous FIFO of tagged pixel words; the head entry is visible without a pop.
module scanout_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  pix_word_t              wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output pix_word_t              head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pix_word_t       mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/vram_scanout.sv
// Display-side read sequencer: walks a frame linearly out of VRAM read port 0
// and presents it as a tagged valid/ready pixel stream.
//
// state | meaning
// IDLE  | no reads issued, waiting for frame_start
// FETCH | issuing reads while FIFO plus in-flight has room
// DRAIN | every frame read issued, waiting for FIFO and pipeline to empty
module vram_scanout
    import vram_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [VRAM_AW-1:0] base_addr,
    output logic [VRAM_AW-1:0] ra,
    input  logic [VRAM_DW-1:0] rd,
    output logic [VRAM_DW-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               busy,
    output logic               underflow
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scan_state_e        state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_AW-1:0] ra_q, ra_d;
    logic               s1_q, s1_d;
    logic [1:0]         s1_tag_q, s1_tag_d;
    logic               s2_q, s2_d;
    logic [1:0]         s2_tag_q, s2_tag_d;
    logic               uf_q, uf_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      pending;
    pix_word_t          fifo_wdata, fifo_head;
    logic               last_x, last_y, drained, active;

    // Stage 1 tracks the cycle ra is on the RAM bus, stage 2 the cycle rd is valid.
    assign pending    = fifo_count + CW'(s1_q) + CW'(s2_q);
    assign last_x     = (x_q == XW'(H_ACTIVE - 1));
    assign last_y     = (y_q == YW'(V_ACTIVE - 1));
    assign drained    = fifo_empty && !s1_q && !s2_q;
    assign active     = (state_q == FETCH) || ((state_q == DRAIN) && !drained);
    assign fifo_pop   = pix_valid && pix_ready;
    assign fifo_wdata = '{eof: s2_tag_q[1], eol: s2_tag_q[0], data: rd};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        ra_d     = ra_q;
        s1_d     = 1'b0;
        s1_tag_d = 2'b00;
        s2_d     = s1_q;
        s2_tag_d = s1_tag_q;
        uf_d     = uf_q;

        if (pix_ready && !pix_valid && active) begin
            uf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
            end
            FETCH: begin
                if (pending < CW'(FIFO_DEPTH)) begin
                    ra_d     = addr_q;
                    addr_d   = addr_q + 1'b1;
                    s1_d     = 1'b1;
                    s1_tag_d = {last_x && last_y, last_x};
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A restart wins over everything: no issue this cycle, in-flight reads dropped.
        if (frame_start) begin
            state_d  = FETCH;
            x_d      = '0;
            y_d      = '0;
            addr_d   = base_addr;
            ra_d     = ra_q;
            s1_d     = 1'b0;
            s1_tag_d = 2'b00;
            s2_d     = 1'b0;
            s2_tag_d = 2'b00;
            uf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            ra_q     <= '0;
            s1_q     <= 1'b0;
            s1_tag_q <= 2'b00;
            s2_q     <= 1'b0;
            s2_tag_q <= 2'b00;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            ra_q     <= ra_d;
            s1_q     <= s1_d;
            s1_tag_q <= s1_tag_d;
            s2_q     <= s2_d;
            s2_tag_q <= s2_tag_d;
            uf_q     <= uf_d;
        end
    end

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s2_q),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .flush_i (frame_start),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign ra        = ra_q;
    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_head.data;
    assign pix_eol   = fifo_head.eol;
    assign pix_eof   = fifo_head.eof;
    assign busy      = (state_q == FETCH);
    assign underflow = uf_q;

endmodule
